// File: rtl/sprite_cmd_pkg.sv
// sprite_cmd_pkg: shared codes, command word layout and FSM states for the sprite command bus.
// SPRITE_CMD_ATTR_EN adds the attribute field to queued requests.
package sprite_cmd_pkg;
  localparam logic [3:0] ACT_UPDATE = 4'h1;
  localparam logic [3:0] ACT_SWAP = 4'hF;
  localparam logic [2:0] TYP_SWAP = 3'b000;
  localparam logic [2:0] TYP_VIS = 3'b001;
  localparam logic [2:0] TYP_X = 3'b010;
  localparam logic [2:0] TYP_Y = 3'b011;
  localparam logic [2:0] TYP_ATTR = 3'b100;
  typedef struct packed {
    logic [5:0]  comp;
    logic [4:0]  child;
    logic [3:0]  action;
    logic [2:0]  typ;
    logic        bf;
    logic [12:0] data;
  } sprite_cmd_t;
  typedef struct packed {
    logic [4:0] child;
    logic       vis;
    logic       flip;
    logic [9:0] x;
    logic [9:0] y;
`ifdef SPRITE_CMD_ATTR_EN
    logic [9:0] attr;
`endif
  } sprite_req_t;
  typedef enum logic [2:0] {S_IDLE, S_VIS, S_X, S_Y, S_ATTR, S_SWAP} state_t;
endpackage

// File: rtl/cmd_req_fifo.sv
// cmd_req_fifo: synchronous request queue of sprite_req_t with full/empty flags.
module cmd_req_fifo
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  sprite_req_t wdata,
  output sprite_req_t rdata,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  sprite_req_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;
  assign rdata = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + AW'(1);
      if (rd) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: queues sprite updates and serialises them into 32-bit command words,
// plus a buffer-swap word per frame. SPRITE_CMD_ATTR_EN enables the fourth (ATTR) word.
module sprite_cmd_encoder
  import sprite_cmd_pkg::*;
#(
  parameter logic [5:0] COMPONENT_ID = 6'b001001,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_child,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  req_attr,
  input  logic        frame_start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic        front_buf,
  output logic        frame_miss
);
  state_t state_q, state_d;
  sprite_req_t cur_q, cur_d, head, req_in;
  sprite_cmd_t w;
  logic front_q, pend_q, miss_q, full, empty, pop, hs, swap_hs;
  always_comb begin
    req_in.child = req_child;
    req_in.vis = req_visible;
    req_in.flip = req_flip;
    req_in.x = req_x;
    req_in.y = req_y;
`ifdef SPRITE_CMD_ATTR_EN
    req_in.attr = req_attr;
`endif
  end
`ifndef SPRITE_CMD_ATTR_EN
  logic unused_attr;
  assign unused_attr = ^req_attr;
`endif
  cmd_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(req_valid & req_ready), .pop(pop),
    .wdata(req_in), .rdata(head), .full(full), .empty(empty)
  );
  assign req_ready = ~full & ~reset;
  assign cmd_valid = state_q != S_IDLE;
  assign hs = cmd_valid & cmd_ready;
  assign swap_hs = hs & (state_q == S_SWAP);
  assign cmd_data = cmd_valid ? w : '0;
  assign front_buf = front_q;
  assign frame_miss = miss_q;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    pop = 1'b0;
    w = '{comp: COMPONENT_ID, child: cur_q.child, action: ACT_UPDATE, typ: TYP_SWAP, bf: ~front_q, data: '0};
    case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_SWAP;
        else if (!empty) begin
          pop = 1'b1;
          cur_d = head;
          state_d = S_VIS;
        end
      end
      S_VIS: begin
        w.typ = TYP_VIS;
        w.data = {cur_q.vis, cur_q.flip, 11'b0};
        if (hs) state_d = S_X;
      end
      S_X: begin
        w.typ = TYP_X;
        w.data = {3'b0, cur_q.x};
        if (hs) state_d = S_Y;
      end
      S_Y: begin
        w.typ = TYP_Y;
        w.data = {3'b0, cur_q.y};
`ifdef SPRITE_CMD_ATTR_EN
        if (hs) state_d = S_ATTR;
`else
        if (hs) state_d = S_IDLE;
`endif
      end
`ifdef SPRITE_CMD_ATTR_EN
      S_ATTR: begin
        w.typ = TYP_ATTR;
        w.data = {3'b0, cur_q.attr};
        if (hs) state_d = S_IDLE;
      end
`endif
      S_SWAP: begin
        w.child = '0;
        w.action = ACT_SWAP;
        if (hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // A frame boundary re-arms the swap even when it lands on the swap handshake itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q <= '0;
      front_q <= 1'b1;
      pend_q <= 1'b1;
      miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      front_q <= front_q ^ swap_hs;
      pend_q <= frame_start | (pend_q & ~swap_hs);
      miss_q <= miss_q | (frame_start & pend_q & ~swap_hs);
    end
  end
endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// tb_sprite_cmd_encoder: directed stimulus with an expected-word queue drained by a monitor.
module tb_sprite_cmd_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [4:0] req_child = '0;
  logic req_visible = 1'b0, req_flip = 1'b0;
  logic [9:0] req_x = '0, req_y = '0, req_attr = '0;
  logic frame_start = 1'b0;
  logic cmd_valid, cmd_ready = 1'b1;
  logic [31:0] cmd_data;
  logic front_buf, frame_miss;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic prev_valid = 1'b0;

  sprite_cmd_encoder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_child(req_child), .req_visible(req_visible), .req_flip(req_flip),
    .req_x(req_x), .req_y(req_y), .req_attr(req_attr), .frame_start(frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .front_buf(front_buf), .frame_miss(frame_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] c, input logic [3:0] a, input logic [2:0] t,
                                     input logic b, input logic [12:0] d);
    return {6'b001001, c, a, t, b, d};
  endfunction

  task automatic push_req(input logic [4:0] c, input logic v, input logic f, input logic [9:0] x,
                          input logic [9:0] y, input logic [9:0] a, input logic b);
    exp_q.push_back(mk(c, 4'h1, 3'b001, b, {v, f, 11'b0}));
    exp_q.push_back(mk(c, 4'h1, 3'b010, b, {3'b0, x}));
    exp_q.push_back(mk(c, 4'h1, 3'b011, b, {3'b0, y}));
`ifdef SPRITE_CMD_ATTR_EN
    exp_q.push_back(mk(c, 4'h1, 3'b100, b, {3'b0, a}));
`endif
  endtask

  // Monitor: every transferred word is checked against the head of the queue.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %h expected none", cmd_data);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_word", cmd_data, e);
        if (e[20:17] == 4'h1 && e[16:14] != 3'b001) chk("no_bubble", 32'(prev_valid), 32'd1);
      end
    end
    prev_valid = cmd_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] c, input logic v, input logic f, input logic [9:0] x,
                      input logic [9:0] y, input logic [9:0] a);
    int t = 0;
    req_child = c; req_visible = v; req_flip = f; req_x = x; req_y = y; req_attr = a;
    req_valid = 1'b1;
    while (!req_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    if (t >= 300) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    tick(3);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    tick(3);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cmd_data", cmd_data, 32'd0);
    exp_q.push_back(32'h241E0000);
    reset = 1'b0;
    chk("rst_front_buf", 32'(front_buf), 32'd1);
    chk("rst_frame_miss", 32'(frame_miss), 32'd0);
    drain();
    chk("init_front_buf", 32'(front_buf), 32'd0);
    chk("init_idle", 32'(cmd_valid), 32'd0);

    exp_q.push_back(32'h24027000);
    exp_q.push_back(32'h2402A064);
    exp_q.push_back(32'h2402E0C8);
`ifdef SPRITE_CMD_ATTR_EN
    exp_q.push_back(32'h24032155);
`endif
    send(5'd0, 1'b1, 1'b0, 10'd100, 10'd200, 10'h155);
    drain();

    cmd_ready = 1'b0;
    exp_q.push_back(32'h24626800);
    exp_q.push_back(32'h2462A005);
    exp_q.push_back(32'h2462E007);
`ifdef SPRITE_CMD_ATTR_EN
    exp_q.push_back(32'h24632009);
`endif
    send(5'd3, 1'b0, 1'b1, 10'd5, 10'd7, 10'd9);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", cmd_data, 32'h24626800);
      chk("stall_valid", 32'(cmd_valid), 32'd1);
      tick(1);
    end
    cmd_ready = 1'b1;
    drain();

    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push_req(5'(k), k[0], k[1], 10'(10 * k), 10'(20 * k), 10'(30 * k), 1'b1);
      send(5'(k), k[0], k[1], 10'(10 * k), 10'(20 * k), 10'(30 * k));
    end
    chk("fifo_full_ready", 32'(req_ready), 32'd0);
    req_child = 5'd6; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fifo_full_hold", 32'(req_ready), 32'd0);
      tick(1);
    end
    push_req(5'd6, 1'b0, 1'b1, 10'd60, 10'd120, 10'd180, 1'b1);
    cmd_ready = 1'b1;
    send(5'd6, 1'b0, 1'b1, 10'd60, 10'd120, 10'd180);
    drain();

    push_req(5'd2, 1'b1, 1'b1, 10'd300, 10'd400, 10'd500, 1'b1);
    exp_q.push_back(32'h241E2000);
    send(5'd2, 1'b1, 1'b1, 10'd300, 10'd400, 10'd500);
    t = 0;
    while (!(cmd_valid && cmd_data[16:14] == 3'b010) && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) chk("x_word_timeout", 32'(t), 32'd0);
    pulse_frame();
    drain();
    chk("swap_front_buf", 32'(front_buf), 32'd1);
    chk("swap_no_miss", 32'(frame_miss), 32'd0);

    cmd_ready = 1'b0;
    pulse_frame();
    tick(2);
    pulse_frame();
    tick(2);
    chk("coalesce_miss", 32'(frame_miss), 32'd1);
    exp_q.push_back(32'h241E0000);
    cmd_ready = 1'b1;
    drain();
    chk("coalesce_front_buf", 32'(front_buf), 32'd0);
    chk("coalesce_single", 32'(cmd_valid), 32'd0);
    chk("miss_sticky", 32'(frame_miss), 32'd1);

    cmd_ready = 1'b0;
    send(5'd9, 1'b1, 1'b1, 10'd1, 10'd2, 10'd3);
    tick(2);
    chk("mid_seq_valid", 32'(cmd_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
    chk("mid_rst_miss", 32'(frame_miss), 32'd0);
    chk("mid_rst_front", 32'(front_buf), 32'd1);
    exp_q.push_back(32'h241E0000);
    reset = 1'b0;
    cmd_ready = 1'b1;
    drain();
    tick(5);
    chk("post_rst_front", 32'(front_buf), 32'd0);
    chk("post_rst_idle", 32'(cmd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
